ui_click_controller: RTL and testbench

Turns raw mouse button levels and cursor position into clean, one-shot UI events for the screen state machine.
- Debounces left and right buttons.
- Hit-tests the cursor against N_BTN rectangular on-screen buttons.
- Emits a single click event with press-and-release-over-same-button semantics, then enforces a hold-off window.
- Sits between the mouse interface and the screen state machine; replaces ad-hoc "wait for release" states there.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/button_debounce.sv | 51 +++++
 rtl/ui_click_controller.sv | 175 +++++++++++++++++
 tb/tb_ui_click_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/UI definitions: coordinate width, screen button rectangles,
// click-controller FSM states and small geometry helpers.
package vga_pkg;

  localparam int UI_COORD_W = 12;

  localparam logic [UI_COORD_W-1:0] RECT_START_X0 = 12'd100;
  localparam logic [UI_COORD_W-1:0] RECT_START_X1 = 12'd199;
  localparam logic [UI_COORD_W-1:0] RECT_START_Y0 = 12'd50;
  localparam logic [UI_COORD_W-1:0] RECT_START_Y1 = 12'd99;
  localparam logic [UI_COORD_W-1:0] RECT_QUIT_X0  = 12'd100;
  localparam logic [UI_COORD_W-1:0] RECT_QUIT_X1  = 12'd199;
  localparam logic [UI_COORD_W-1:0] RECT_QUIT_Y0  = 12'd150;
  localparam logic [UI_COORD_W-1:0] RECT_QUIT_Y1  = 12'd199;

  // Packed region tables for the click controller; index 0 is START, 1 is QUIT.
  localparam int UI_SCREEN_N_BTN = 2;
  localparam logic [UI_SCREEN_N_BTN*UI_COORD_W-1:0] UI_SCREEN_BTN_X0 = {RECT_QUIT_X0, RECT_START_X0};
  localparam logic [UI_SCREEN_N_BTN*UI_COORD_W-1:0] UI_SCREEN_BTN_X1 = {RECT_QUIT_X1, RECT_START_X1};
  localparam logic [UI_SCREEN_N_BTN*UI_COORD_W-1:0] UI_SCREEN_BTN_Y0 = {RECT_QUIT_Y0, RECT_START_Y0};
  localparam logic [UI_SCREEN_N_BTN*UI_COORD_W-1:0] UI_SCREEN_BTN_Y1 = {RECT_QUIT_Y1, RECT_START_Y1};

  typedef enum logic [1:0] {
    UI_IDLE    = 2'd0,
    UI_ARMED   = 2'd1,
    UI_BLOCKED = 2'd2,
    UI_HOLDOFF = 2'd3
  } ui_click_state_t;

  function automatic int clog2_min1(input int value);
    return (value > 32'sd1) ? $clog2(value) : 32'sd1;
  endfunction

  // Inclusive unsigned containment; an inverted rectangle can never contain a point.
  function automatic logic in_rect(
    input logic [UI_COORD_W-1:0] x,
    input logic [UI_COORD_W-1:0] y,
    input logic [UI_COORD_W-1:0] x0,
    input logic [UI_COORD_W-1:0] x1,
    input logic [UI_COORD_W-1:0] y0,
    input logic [UI_COORD_W-1:0] y1
  );
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Registers a raw button level, filters it with a stability counter and
// derives single-cycle rise/fall pulses from the filtered level.
module button_debounce
  import vga_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 65536,
  parameter logic RESET_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             raw_r;
  logic             level_r;
  logic             level_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Input register, stability counter and filtered level; the raw register
  // starts at the filtered level so reset itself never counts as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_r     <= RESET_LEVEL;
      level_r   <= RESET_LEVEL;
      level_d_r <= RESET_LEVEL;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      raw_r     <= raw;
      level_d_r <= level_r;
      if (raw_r == level_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        level_r <= raw_r;
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_d_r;
  assign fall  = ~level_r & level_d_r;

endmodule

// File: rtl/ui_click_controller.sv
// Debounced mouse buttons plus rectangle hit-testing, producing one-shot
// click events with press/release-over-same-button semantics and a hold-off.
module ui_click_controller
  import vga_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 65536,
  parameter int HOLDOFF_CYC  = 2000000,
  parameter int ID_W         = clog2_min1(N_BTN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mouse_left,
  input  logic                        mouse_right,
  input  logic [UI_COORD_W-1:0]       xpos,
  input  logic [UI_COORD_W-1:0]       ypos,
  input  logic [N_BTN*UI_COORD_W-1:0] btn_x0,
  input  logic [N_BTN*UI_COORD_W-1:0] btn_x1,
  input  logic [N_BTN*UI_COORD_W-1:0] btn_y0,
  input  logic [N_BTN*UI_COORD_W-1:0] btn_y1,
  input  logic [N_BTN-1:0]            btn_enable,
  output logic                        hover_valid,
  output logic [ID_W-1:0]             hover_id,
  output logic                        click_valid,
  output logic [ID_W-1:0]             click_id,
  output logic                        right_click,
  output logic                        busy
);

  localparam int HOLD_W = clog2_min1(HOLDOFF_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_CYC - 1);

  logic left_level_s, left_rise_s, left_fall_s;
  logic right_level_s, right_rise_s, right_fall_s;
  logic unused_s;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_LEVEL(1'b1)) u_left_db (
    .clk(clk), .rst(rst), .raw(mouse_left),
    .level(left_level_s), .rise(left_rise_s), .fall(left_fall_s)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_LEVEL(1'b1)) u_right_db (
    .clk(clk), .rst(rst), .raw(mouse_right),
    .level(right_level_s), .rise(right_rise_s), .fall(right_fall_s)
  );

  assign unused_s = ^{left_level_s, right_level_s, right_fall_s};

  logic            hit_valid_s;
  logic [ID_W-1:0] hit_id_s;
  logic            hover_valid_r;
  logic [ID_W-1:0] hover_id_r;

  // Priority hit test: scanning downwards lets the lowest matching index win.
  always_comb begin
    hit_valid_s = 1'b0;
    hit_id_s    = {ID_W{1'b0}};
    for (int i = N_BTN - 1; i >= 0; i--) begin
      logic match_s;
      match_s = btn_enable[i] &&
                in_rect(xpos, ypos,
                        btn_x0[i*UI_COORD_W +: UI_COORD_W], btn_x1[i*UI_COORD_W +: UI_COORD_W],
                        btn_y0[i*UI_COORD_W +: UI_COORD_W], btn_y1[i*UI_COORD_W +: UI_COORD_W]);
      hit_valid_s = hit_valid_s | match_s;
      hit_id_s    = match_s ? ID_W'(i) : hit_id_s;
    end
  end

  // Hover register gives the FSM a stable, one-cycle-late view of the cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      hover_valid_r <= 1'b0;
      hover_id_r    <= {ID_W{1'b0}};
    end else begin
      hover_valid_r <= hit_valid_s;
      hover_id_r    <= hit_id_s;
    end
  end

  ui_click_state_t state_r, next_state_s;
  logic [ID_W-1:0]   armed_id_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              arm_s;
  logic              fire_s;

  // Next-state logic for the left-button click FSM.
  always_comb begin
    next_state_s = state_r;
    arm_s        = 1'b0;
    fire_s       = 1'b0;
    case (state_r)
      UI_IDLE: begin
        if (left_rise_s) begin
          if (hover_valid_r) begin
            arm_s        = 1'b1;
            next_state_s = UI_ARMED;
          end else begin
            next_state_s = UI_BLOCKED;
          end
        end else begin
          next_state_s = UI_IDLE;
        end
      end
      UI_ARMED: begin
        if (left_fall_s) begin
          if (hover_valid_r && (hover_id_r == armed_id_r)) begin
            fire_s       = 1'b1;
            next_state_s = UI_HOLDOFF;
          end else begin
            next_state_s = UI_IDLE;
          end
        end else begin
          next_state_s = UI_ARMED;
        end
      end
      UI_BLOCKED: begin
        if (left_fall_s) begin
          next_state_s = UI_IDLE;
        end else begin
          next_state_s = UI_BLOCKED;
        end
      end
      UI_HOLDOFF: begin
        if (hold_cnt_r == HOLD_MAX) begin
          next_state_s = UI_IDLE;
        end else begin
          next_state_s = UI_HOLDOFF;
        end
      end
      default: next_state_s = UI_IDLE;
    endcase
  end

  logic            click_valid_r;
  logic [ID_W-1:0] click_id_r;
  logic            right_click_r;
  logic            busy_r;

  // FSM state, armed region, hold-off counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= UI_IDLE;
      armed_id_r    <= {ID_W{1'b0}};
      hold_cnt_r    <= {HOLD_W{1'b0}};
      click_valid_r <= 1'b0;
      click_id_r    <= {ID_W{1'b0}};
      right_click_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (arm_s) begin
        armed_id_r <= hover_id_r;
      end
      if ((state_r == UI_HOLDOFF) && (next_state_s == UI_HOLDOFF)) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end
      click_valid_r <= fire_s;
      if (fire_s) begin
        click_id_r <= armed_id_r;
      end
      right_click_r <= right_rise_s;
      busy_r        <= (next_state_s != UI_IDLE);
    end
  end

  assign hover_valid = hover_valid_r;
  assign hover_id    = hover_id_r;
  assign click_valid = click_valid_r;
  assign click_id    = click_id_r;
  assign right_click = right_click_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ui_click_controller.sv
// Bench for ui_click_controller: directed scenarios plus a randomized phase,
// every cycle checked against an event-level reference model.
module tb_ui_click_controller;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int ID_W  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mouse_left = 1'b0;
  logic              mouse_right = 1'b0;
  logic [11:0]       xpos = 12'd0;
  logic [11:0]       ypos = 12'd0;
  logic [23:0]       btn_x0, btn_x1, btn_y0, btn_y1;
  logic [1:0]        btn_enable;
  logic              hover_valid, click_valid, right_click, busy;
  logic [ID_W-1:0]   hover_id, click_id;

  always #5 clk = ~clk;

  ui_click_controller #(
    .N_BTN(N_BTN), .DEBOUNCE_CYC(DEB), .HOLDOFF_CYC(HOLD), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_right(mouse_right),
    .xpos(xpos), .ypos(ypos), .btn_x0(btn_x0), .btn_x1(btn_x1),
    .btn_y0(btn_y0), .btn_y1(btn_y1), .btn_enable(btn_enable),
    .hover_valid(hover_valid), .hover_id(hover_id), .click_valid(click_valid),
    .click_id(click_id), .right_click(right_click), .busy(busy)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: filtered level changes once the registered raw value has
  // differed from it for DEB consecutive edges (tracked with timestamps);
  // the click logic is a "pressed-on" record plus a hold-off countdown.
  int t_edge = 0;
  bit m_raw[2]  = '{1'b1, 1'b1};
  bit m_flt[2]  = '{1'b1, 1'b1};
  bit m_fltd[2] = '{1'b1, 1'b1};
  int m_streak[2] = '{0, 0};
  int m_tog[2]    = '{0, 0};
  bit m_hv = 1'b0;
  int m_hid = 0;
  int m_press = -1;   // -1 none, -2 pressed off-target, else pressed region
  int m_hold = 0;
  bit e_click = 1'b0;
  int e_cid = 0;
  bit e_right = 1'b0;

  int n_click, n_right, n_busy, last_cid, pc_busy;
  bit pc_on;

  function automatic int ref_hit();
    for (int i = 0; i < N_BTN; i++) begin
      int x0, x1, y0, y1;
      x0 = btn_x0[i*12 +: 12]; x1 = btn_x1[i*12 +: 12];
      y0 = btn_y0[i*12 +: 12]; y1 = btn_y1[i*12 +: 12];
      if (btn_enable[i] && xpos >= x0 && xpos <= x1 && ypos >= y0 && ypos <= y1) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit rise_l, fall_l, rise_r;
    bit nin[2];
    int start, h;
    t_edge++;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_raw[b] = 1'b1; m_flt[b] = 1'b1; m_fltd[b] = 1'b1;
        m_streak[b] = t_edge + 1; m_tog[b] = t_edge;
      end
      m_hv = 1'b0; m_hid = 0; m_press = -1; m_hold = 0;
      e_click = 1'b0; e_cid = 0; e_right = 1'b0;
      return;
    end
    rise_l = m_flt[0] & ~m_fltd[0];
    fall_l = ~m_flt[0] & m_fltd[0];
    rise_r = m_flt[1] & ~m_fltd[1];
    e_click = 1'b0;
    e_right = rise_r;
    if (m_hold > 0) m_hold--;
    else if (m_press == -1) begin
      if (rise_l) m_press = m_hv ? m_hid : -2;
    end else if (fall_l) begin
      if (m_press >= 0 && m_hv && m_hid == m_press) begin
        e_click = 1'b1; e_cid = m_press; m_hold = HOLD;
      end
      m_press = -1;
    end
    nin[0] = mouse_left; nin[1] = mouse_right;
    for (int b = 0; b < 2; b++) begin
      m_fltd[b] = m_flt[b];
      start = (m_streak[b] > m_tog[b] + 1) ? m_streak[b] : m_tog[b] + 1;
      if (m_raw[b] != m_flt[b] && t_edge - start + 1 >= DEB) begin
        m_flt[b] = m_raw[b]; m_tog[b] = t_edge;
      end
      if (nin[b] != m_raw[b]) begin
        m_raw[b] = nin[b]; m_streak[b] = t_edge + 1;
      end
    end
    h = ref_hit();
    m_hv = (h >= 0);
    m_hid = (h >= 0) ? h : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("hover_valid", hover_valid, m_hv);
    chk("hover_id", hover_id, m_hid);
    chk("click_valid", click_valid, e_click);
    chk("click_id", click_id, e_cid);
    chk("right_click", right_click, e_right);
    chk("busy", busy, (m_hold > 0 || m_press != -1));
    if (click_valid === 1'b1) begin
      n_click++; last_cid = click_id; pc_on = 1'b1; pc_busy = 0;
    end
    if (pc_on) begin
      if (busy === 1'b1) pc_busy++;
      else pc_on = 1'b0;
    end
    if (right_click === 1'b1) n_right++;
    if (busy === 1'b1) n_busy++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_stats();
    n_click = 0; n_right = 0; n_busy = 0; last_cid = -1; pc_busy = 0; pc_on = 1'b0;
  endtask

  task automatic set_cur(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
  endtask

  task automatic wait_click(input int max_cyc);
    int k = 0;
    while (click_valid !== 1'b1 && k < max_cyc) begin
      tick(); k++;
    end
    chk("click_wait", click_valid, 1'b1);
  endtask

  initial begin
    btn_x0 = {12'd100, 12'd100}; btn_x1 = {12'd199, 12'd199};
    btn_y0 = {12'd150, 12'd50};  btn_y1 = {12'd199, 12'd99};
    btn_enable = 2'b11;
    clr_stats();
    rst = 1'b1;
    run(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_click_id", click_id, 1'b0);
    rst = 1'b0;
    run(12);

    // Basic click in region 0
    clr_stats();
    set_cur(100 + $urandom_range(0, 99), 50 + $urandom_range(0, 49));
    mouse_left = 1'b1; run(10);
    mouse_left = 1'b0;
    wait_click(20);
    run(15);
    chk("s1_clicks", n_click, 1);
    chk("s1_click_id", last_cid, 0);
    chk("s1_holdoff_busy", pc_busy, HOLD);

    // Move off the pressed region before release
    clr_stats();
    set_cur(150, 70);
    mouse_left = 1'b1; run(10);
    set_cur(150, 170); run(5);
    mouse_left = 1'b0; run(20);
    chk("s2_clicks", n_click, 0);
    chk("s2_idle", busy, 1'b0);

    // Bouncing contact never settles long enough
    clr_stats();
    set_cur(150, 70);
    for (int i = 0; i < 10; i++) begin
      mouse_left = ~mouse_left; run(2);
    end
    mouse_left = 1'b0; run(15);
    chk("s3_clicks", n_click, 0);
    chk("s3_never_busy", n_busy, 0);

    // Press outside any region, then slide onto one
    clr_stats();
    set_cur(10, 10);
    mouse_left = 1'b1; run(10);
    set_cur(150, 70); run(5);
    mouse_left = 1'b0; run(20);
    chk("s4_clicks", n_click, 0);
    chk("s4_blocked_busy", (n_busy > 0), 1'b1);

    // Boundary pixel click in region 1, second press inside hold-off
    clr_stats();
    set_cur(150, 199); run(2);
    chk("s5_hover_valid", hover_valid, 1'b1);
    chk("s5_hover_id", hover_id, 1'b1);
    mouse_left = 1'b1; run(8);
    mouse_left = 1'b0;
    wait_click(20);
    mouse_left = 1'b1; run(5);
    mouse_left = 1'b0; run(30);
    chk("s5_clicks", n_click, 1);
    chk("s5_click_id", last_cid, 1);

    // Left held through reset, then a real click with a right click mid-press
    clr_stats();
    set_cur(150, 70);
    mouse_left = 1'b1; rst = 1'b1; run(3);
    rst = 1'b0; run(10);
    mouse_left = 1'b0; run(15);
    chk("s6_no_click_after_rst", n_click, 0);
    mouse_left = 1'b1; run(7);
    mouse_right = 1'b1; run(6);
    mouse_right = 1'b0; run(2);
    mouse_left = 1'b0; run(20);
    chk("s6_clicks", n_click, 1);
    chk("s6_right_clicks", n_right, 1);
    chk("s6_click_id", last_cid, 0);

    // Reset while armed aborts the click
    clr_stats();
    set_cur(150, 160);
    mouse_left = 1'b1; run(10);
    rst = 1'b1; run(1);
    rst = 1'b0; run(3);
    mouse_left = 1'b0; run(20);
    chk("s7_clicks", n_click, 0);

    // Overlap priority, enable masking and an inverted rectangle
    btn_y0[12 +: 12] = 12'd50;
    set_cur(150, 70); run(2);
    chk("ovl_valid", hover_valid, 1'b1);
    chk("ovl_lowest", hover_id, 1'b0);
    btn_enable = 2'b10; run(2);
    chk("ovl_masked", hover_id, 1'b1);
    btn_enable = 2'b11;
    btn_y0[12 +: 12] = 12'd150;
    btn_x0[12 +: 12] = 12'd200; btn_x1[12 +: 12] = 12'd150;
    set_cur(170, 170); run(2);
    chk("inverted_rect", hover_valid, 1'b0);
    btn_x0[12 +: 12] = 12'd100; btn_x1[12 +: 12] = 12'd199;

    // Randomized traffic checked cycle by cycle against the model
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 3))
        0: set_cur(100 + $urandom_range(0, 99), 50 + $urandom_range(0, 49));
        1: set_cur(100 + $urandom_range(0, 99), 150 + $urandom_range(0, 49));
        2: set_cur(($urandom_range(0, 1) != 0) ? 199 : 100, ($urandom_range(0, 1) != 0) ? 199 : 99);
        default: set_cur($urandom_range(0, 4095), $urandom_range(0, 4095));
      endcase
      mouse_left  = ($urandom_range(0, 1) != 0);
      mouse_right = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) btn_enable = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 39) == 0);
      run($urandom_range(1, 12));
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
